ov_cam_init_seq: RTL and testbench
==================================

Name: ov_cam_init_seq

Overview:
Sequencer that owns the shared SCCB master and programs both stereo cameras from a register table after power-up.
- Walks table entries, issues one SCCB write per entry, and honours delay/end markers.
- Repeats the table for camera 0, then camera 1, and after that serves single host write requests.
- Sits between the camera-power/reset logic and the SCCB master; the pixel capture path waits on cfg_done.

Parameters:
TABLE_DEPTH, 256, number of 16-bit table entries (index width = clog2)
CAM0_ADDR, 8'h42, SCCB write address of camera 0
CAM1_ADDR, 8'h42, SCCB write address of camera 1 (separate buses, routed by cam_sel)
PWRUP_TICKS, 20'd1000000, clk cycles held in power-up wait before the first write
DLY_UNIT, 16'd50000, clk cycles per delay unit in a delay entry
TIMEOUT_TICKS, 20'd500000, max clk cycles waiting on one SCCB transaction

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sccb_addr  out  8  device address to SCCB master
sccb_subaddr  out  8  register address to SCCB master
sccb_wdata  out  8  write data to SCCB master
sccb_start  out  1  one-cycle start pulse to SCCB master
sccb_busy  in  1  SCCB master busy
cam_sel  out  1  0 = route SCCB bus to camera 0, 1 = camera 1
host_req  in  1  host register-write request (level, held until ack)
host_cam  in  1  target camera for host request
host_subaddr  in  8  host register address
host_wdata  in  8  host write data
host_ack  out  1  one-cycle pulse when host write completes or times out
cfg_done  out  1  high once both cameras are configured; sticky until reset
cfg_err  out  1  sticky; set on any SCCB timeout
entry_idx  out  clog2(TABLE_DEPTH)  current table index (debug)

Behaviour:
- Reset values: all outputs 0, sccb_addr=CAM0_ADDR, state=S_PWRUP, counters 0.
- Reset asserted mid-transaction aborts immediately; no further sccb_start is issued.
- Table ROM is a sub-module with 1-cycle read latency. Entry = {subaddr[15:8], data[7:0]}.
  - 16'hFFFF = end of table.
  - {8'hFE, n} = delay n*DLY_UNIT cycles; n=0 means no delay.
  - Any other value = register write.
  - Reaching TABLE_DEPTH-1 without an end entry is treated as end of table.
- States:
  - S_PWRUP: count PWRUP_TICKS, then go to S_FETCH.
  - S_FETCH: drive rom address = entry_idx; next cycle go to S_DECODE.
  - S_DECODE: on end, go to S_NEXT_CAM; on delay, load counter and go to S_DELAY; on write, latch subaddr/wdata, set sccb_addr from cam_sel, go to S_ISSUE.
  - S_ISSUE: pulse sccb_start for exactly 1 cycle, go to S_WAIT_HI.
  - S_WAIT_HI: wait for sccb_busy=1, then go to S_WAIT_LO. Falling edge of busy = transaction complete.
  - S_WAIT_LO: on busy falling, increment entry_idx and go to S_FETCH, or in host mode go to S_READY and pulse host_ack.
  - S_DELAY: count down, then increment entry_idx and go to S_FETCH.
  - S_NEXT_CAM: if cam_sel=0, set cam_sel=1, entry_idx=0, go to S_FETCH; else set cfg_done=1 and go to S_READY.
  - S_READY: if host_req, latch host_cam into cam_sel and latch subaddr/wdata, then go to S_ISSUE (host mode).
- Timeout: one counter spans S_WAIT_HI plus S_WAIT_LO. Reaching TIMEOUT_TICKS sets cfg_err and skips the entry (host mode: ack anyway). Sequencing continues.
- Outputs sccb_addr, sccb_subaddr and sccb_wdata are stable from S_ISSUE until the busy fall.
- host_req is ignored until cfg_done. Only one host transaction is in flight at a time. host_req must be dropped the cycle after host_ack, or it is re-served.
- cam_sel changes only in S_NEXT_CAM or S_READY, never while SCCB is busy.

Decomposition:
- Package ov_cfg_pkg: state enum; constants for the end marker 16'hFFFF and delay tag 8'hFE; entry typedef struct {subaddr, data}.
- Sub-module ov_cfg_rom: synchronous ROM, TABLE_DEPTH x 16, contents from an init file.

Test Plan:
- Table {0x1280, 0xFE02, 0x1100, 0xFFFF}, DLY_UNIT=10, BFM busy 20 cycles:
  - cam 0 then cam 1 each see writes 12:80 and 11:00.
  - Gap of ≥20 cycles between the two writes.
  - cfg_done rises after the 4th write, cfg_err=0.
- BFM never raises busy, TIMEOUT_TICKS=100:
  - cfg_err set ~100 cycles after the first start.
  - entry_idx advances, sequence still completes, cfg_done=1.
- After cfg_done, host_req with cam=1, sub=0x3A, data=0x04:
  - one sccb_start with addr CAM1_ADDR, subaddr 0x3A, wdata 0x04.
  - host_ack pulses 1 cycle after busy falls; cam_sel=1.
- host_req asserted during init:
  - no host transaction until cfg_done.
  - then exactly one transaction, one ack.
- Reset asserted while busy=1 mid-write:
  - next cycle all outputs at reset values, state S_PWRUP.
  - no start pulse for PWRUP_TICKS.
- Table with no end marker, TABLE_DEPTH=4:
  - all 4 entries written per camera, then wraps to cam 1, then cfg_done.

Source files
------------

// File: rtl/ov_cfg_pkg.sv
// Shared types and constants for the camera init sequencer.
package ov_cfg_pkg;

   typedef enum logic [3:0] {
      S_PWRUP,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_DELAY,
      S_NEXT_CAM,
      S_READY
   } state_t;

   localparam logic [15:0] END_MARK = 16'hFFFF;
   localparam logic [7:0]  DLY_TAG  = 8'hFE;
   localparam int          CNT_W    = 24;

   typedef struct packed {
      logic [7:0] subaddr;
      logic [7:0] data;
   } entry_t;

endpackage

// File: rtl/ov_cfg_rom.sv
// Register table ROM, one-cycle read latency.
// The image is packed into ROM_INIT with entry i at bits [16*i +: 16];
// the build flow generates it from the table init file.
module ov_cfg_rom
   import ov_cfg_pkg::*;
#(
   parameter int                        TABLE_DEPTH = 256,
   parameter int                        IDX_W       = $clog2(TABLE_DEPTH),
   parameter logic [TABLE_DEPTH*16-1:0] ROM_INIT    = '1
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   output entry_t           rdata
);

   // registered read of the addressed entry
   always_ff @(posedge clk) begin
      rdata <= ROM_INIT[{addr, 4'b0000} +: 16];
   end

endmodule

// File: rtl/ov_cam_init_seq.sv
// Camera init sequencer: walks the register table once per camera over the
// shared SCCB master, then serves single host register writes.
//
// state      | meaning
// S_PWRUP    | wait PWRUP_TICKS after reset before touching the bus
// S_FETCH    | ROM address = entry_idx
// S_DECODE   | classify entry: end / delay / register write
// S_ISSUE    | one-cycle sccb_start
// S_WAIT_HI  | wait for SCCB master to go busy (timeout running)
// S_WAIT_LO  | wait for busy to fall (timeout running)
// S_DELAY    | count down n*DLY_UNIT
// S_NEXT_CAM | switch to camera 1 or finish configuration
// S_READY    | configured; accept host writes
module ov_cam_init_seq
   import ov_cfg_pkg::*;
#(
   parameter int                        TABLE_DEPTH   = 256,
   parameter logic [7:0]                CAM0_ADDR     = 8'h42,
   parameter logic [7:0]                CAM1_ADDR     = 8'h42,
   parameter logic [19:0]               PWRUP_TICKS   = 20'd1000000,
   parameter logic [15:0]               DLY_UNIT      = 16'd50000,
   parameter logic [19:0]               TIMEOUT_TICKS = 20'd500000,
   parameter logic [TABLE_DEPTH*16-1:0] ROM_INIT      = '1
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic [7:0]                     sccb_addr,
   output logic [7:0]                     sccb_subaddr,
   output logic [7:0]                     sccb_wdata,
   output logic                           sccb_start,
   input  logic                           sccb_busy,
   output logic                           cam_sel,
   input  logic                           host_req,
   input  logic                           host_cam,
   input  logic [7:0]                     host_subaddr,
   input  logic [7:0]                     host_wdata,
   output logic                           host_ack,
   output logic                           cfg_done,
   output logic                           cfg_err,
   output logic [$clog2(TABLE_DEPTH)-1:0] entry_idx
);

   localparam int               IDX_W    = $clog2(TABLE_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);
   localparam logic [CNT_W-1:0] PWRUP_TC = CNT_W'(PWRUP_TICKS) - CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_TC   = CNT_W'(TIMEOUT_TICKS) - CNT_W'(1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       addr_q, addr_d, sub_q, sub_d, wdata_q, wdata_d;
   logic             cam_q, cam_d, done_q, done_d, err_q, err_d, ack_q, ack_d;
   logic             xact_end, step;
   entry_t           rom_q;

   ov_cfg_rom #(
      .TABLE_DEPTH (TABLE_DEPTH),
      .IDX_W       (IDX_W),
      .ROM_INIT    (ROM_INIT)
   ) u_rom (
      .clk   (clk),
      .addr  (idx_q),
      .rdata (rom_q)
   );

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_PWRUP;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= CAM0_ADDR;
         sub_q   <= '0;
         wdata_q <= '0;
         cam_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         sub_q   <= sub_d;
         wdata_q <= wdata_d;
         cam_q   <= cam_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   // next-state and datapath updates
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      sub_d    = sub_q;
      wdata_d  = wdata_q;
      cam_d    = cam_q;
      done_d   = done_q;
      err_d    = err_q;
      ack_d    = 1'b0;
      xact_end = 1'b0;
      step     = 1'b0;
      case (state_q)
         S_PWRUP: begin
            if (cnt_q == PWRUP_TC) begin
               cnt_d   = '0;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (rom_q == END_MARK) begin
               state_d = S_NEXT_CAM;
            end else if (rom_q.subaddr == DLY_TAG) begin
               cnt_d   = CNT_W'(rom_q.data) * CNT_W'(DLY_UNIT);
               state_d = S_DELAY;
            end else begin
               sub_d   = rom_q.subaddr;
               wdata_d = rom_q.data;
               addr_d  = cam_q ? CAM1_ADDR : CAM0_ADDR;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TMO_TC) begin
               err_d    = 1'b1;
               xact_end = 1'b1;
            end else if (sccb_busy) begin
               state_d = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!sccb_busy) begin
               xact_end = 1'b1;
            end else if (cnt_q == TMO_TC) begin
               err_d    = 1'b1;
               xact_end = 1'b1;
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) step = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
         end
         S_NEXT_CAM: begin
            if (!cam_q) begin
               cam_d   = 1'b1;
               idx_d   = '0;
               state_d = S_FETCH;
            end else begin
               done_d  = 1'b1;
               state_d = S_READY;
            end
         end
         S_READY: begin
            // ack_q still high means the request being seen is the one just served
            if (host_req && !ack_q) begin
               cam_d   = host_cam;
               addr_d  = host_cam ? CAM1_ADDR : CAM0_ADDR;
               sub_d   = host_subaddr;
               wdata_d = host_wdata;
               state_d = S_ISSUE;
            end
         end
         default: state_d = S_PWRUP;
      endcase
      // once configured every transaction is a host write
      if (xact_end) begin
         if (done_q) begin
            ack_d   = 1'b1;
            state_d = S_READY;
         end else begin
            step = 1'b1;
         end
      end
      // last slot doubles as an implicit end marker
      if (step) begin
         if (idx_q == LAST_IDX) begin
            state_d = S_NEXT_CAM;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_FETCH;
         end
      end
   end

   assign sccb_start   = (state_q == S_ISSUE);
   assign sccb_addr    = addr_q;
   assign sccb_subaddr = sub_q;
   assign sccb_wdata   = wdata_q;
   assign cam_sel      = cam_q;
   assign host_ack     = ack_q;
   assign cfg_done     = done_q;
   assign cfg_err      = err_q;
   assign entry_idx    = idx_q;

endmodule

// File: tb/tb_ov_cam_init_seq.sv
// Bench for ov_cam_init_seq: two instances (table with end/delay markers,
// and a 4-entry table without end marker), SCCB master BFMs, and a
// scoreboard monitor that checks every start pulse against an expected queue.
module tb_ov_cam_init_seq;
   import ov_cfg_pkg::*;

   localparam logic [7:0]  CAM0     = 8'h42;
   localparam logic [7:0]  CAM1     = 8'h43;
   localparam logic [19:0] PWRUP    = 20'd30;
   localparam int          BUSY_CYC = 20;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] sub;
      logic [7:0] data;
      logic       cam;
      logic       dly;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b, sel_b, silent_a;
   logic       host_req, host_cam;
   logic [7:0] host_sub, host_wdata;
   logic [7:0] addr_a, sub_a, wdata_a, addr_b, sub_b, wdata_b;
   logic       start_a, busy_a, cam_a, ack_a, done_a, err_a;
   logic       start_b, busy_b, cam_b, ack_b, done_b, err_b;
   logic [1:0] idx_a, idx_b;
   int         bc_a, bc_b;

   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, n_starts = 0, n_acks = 0, last_start = -1000;
   int   err_cyc = 0, first_cyc = 0;
   logic [1:0] err_idx = '0;
   logic       err_prev = 1'b0;
   logic [1:0] busy_hist = '0;
   exp_t exp_q[$];

   ov_cam_init_seq #(
      .TABLE_DEPTH(4), .CAM0_ADDR(CAM0), .CAM1_ADDR(CAM1), .PWRUP_TICKS(PWRUP),
      .DLY_UNIT(16'd10), .TIMEOUT_TICKS(20'd100),
      .ROM_INIT(64'hFFFF_1100_FE02_1280)
   ) dut_a (
      .clk(clk), .reset(reset_a), .sccb_addr(addr_a), .sccb_subaddr(sub_a),
      .sccb_wdata(wdata_a), .sccb_start(start_a), .sccb_busy(busy_a), .cam_sel(cam_a),
      .host_req(host_req), .host_cam(host_cam), .host_subaddr(host_sub),
      .host_wdata(host_wdata), .host_ack(ack_a), .cfg_done(done_a), .cfg_err(err_a),
      .entry_idx(idx_a)
   );

   ov_cam_init_seq #(
      .TABLE_DEPTH(4), .CAM0_ADDR(CAM0), .CAM1_ADDR(CAM1), .PWRUP_TICKS(PWRUP),
      .DLY_UNIT(16'd10), .TIMEOUT_TICKS(20'd100),
      .ROM_INIT(64'h1503_1402_1301_1280)
   ) dut_b (
      .clk(clk), .reset(reset_b), .sccb_addr(addr_b), .sccb_subaddr(sub_b),
      .sccb_wdata(wdata_b), .sccb_start(start_b), .sccb_busy(busy_b), .cam_sel(cam_b),
      .host_req(host_req), .host_cam(host_cam), .host_subaddr(host_sub),
      .host_wdata(host_wdata), .host_ack(ack_b), .cfg_done(done_b), .cfg_err(err_b),
      .entry_idx(idx_b)
   );

   logic       m_start, m_busy, m_cam, m_ack, m_done, m_err;
   logic [7:0] m_addr, m_sub, m_wdata;
   logic [1:0] m_idx;
   assign m_start = sel_b ? start_b : start_a;
   assign m_busy  = sel_b ? busy_b  : busy_a;
   assign m_cam   = sel_b ? cam_b   : cam_a;
   assign m_ack   = sel_b ? ack_b   : ack_a;
   assign m_done  = sel_b ? done_b  : done_a;
   assign m_err   = sel_b ? err_b   : err_a;
   assign m_addr  = sel_b ? addr_b  : addr_a;
   assign m_sub   = sel_b ? sub_b   : sub_a;
   assign m_wdata = sel_b ? wdata_b : wdata_a;
   assign m_idx   = sel_b ? idx_b   : idx_a;

   // SCCB master BFM for dut_a: busy for BUSY_CYC cycles per start, or mute
   always @(posedge clk) begin
      if (reset_a) begin
         busy_a <= 1'b0; bc_a <= 0;
      end else if (start_a && !silent_a) begin
         busy_a <= 1'b1; bc_a <= BUSY_CYC - 1;
      end else if (busy_a) begin
         if (bc_a == 0) busy_a <= 1'b0;
         else           bc_a <= bc_a - 1;
      end
   end

   // SCCB master BFM for dut_b
   always @(posedge clk) begin
      if (reset_b) begin
         busy_b <= 1'b0; bc_b <= 0;
      end else if (start_b) begin
         busy_b <= 1'b1; bc_b <= BUSY_CYC - 1;
      end else if (busy_b) begin
         if (bc_b == 0) busy_b <= 1'b0;
         else           bc_b <= bc_b - 1;
      end
   end

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                       input logic c, input logic dl);
      exp_t e;
      e.addr = a; e.sub = s; e.data = d; e.cam = c; e.dly = dl;
      exp_q.push_back(e);
   endtask

   // scoreboard monitor: compares every start pulse, ack latency, error rise
   always @(negedge clk) begin
      exp_t e;
      if (m_start) begin
         if (exp_q.size() == 0) begin
            chk("start_expected", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("start_addr",  32'(m_addr),  32'(e.addr));
            chk("start_sub",   32'(m_sub),   32'(e.sub));
            chk("start_wdata", 32'(m_wdata), 32'(e.data));
            chk("start_cam",   32'(m_cam),   32'(e.cam));
            if (e.dly) chk_rng("delay_gap", cyc - last_start, 40, 10000);
         end
         last_start = cyc;
         n_starts++;
      end
      if (m_ack) begin
         n_acks++;
         chk("ack_after_busy_fall", 32'(busy_hist), 32'h2);
      end
      if (m_err && !err_prev) begin
         err_cyc = cyc;
         err_idx = m_idx;
      end
      err_prev  = m_err;
      busy_hist = {busy_hist[0], m_busy};
   end

   task automatic push_table_a();
      push(CAM0, 8'h12, 8'h80, 1'b0, 1'b0);
      push(CAM0, 8'h11, 8'h00, 1'b0, 1'b1);
      push(CAM1, 8'h12, 8'h80, 1'b1, 1'b0);
      push(CAM1, 8'h11, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic wait_done(input string nm);
      int k = 0;
      while (!m_done && k < 3000) begin @(negedge clk); k++; end
      chk(nm, 32'(m_done), 32'd1);
   endtask

   task automatic wait_ack(input string nm);
      int k = 0;
      while (k < 300) begin
         @(negedge clk); k++;
         if (m_ack) break;
      end
      chk(nm, 32'(m_ack), 32'd1);
   endtask

   initial begin
      int base, k;
      reset_a = 1'b1; reset_b = 1'b1; sel_b = 1'b0; silent_a = 1'b0;
      host_req = 1'b0; host_cam = 1'b0; host_sub = '0; host_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_addr",  32'(addr_a),       32'(CAM0));
      chk("rst_start", 32'(start_a),      32'd0);
      chk("rst_done",  32'(done_a),       32'd0);
      chk("rst_state", 32'(dut_a.state_q), 32'(S_PWRUP));

      // table walk, with a host request already pending during init
      push_table_a();
      push(CAM0, 8'h55, 8'h66, 1'b0, 1'b0);
      host_req = 1'b1; host_cam = 1'b0; host_sub = 8'h55; host_wdata = 8'h66;
      base = n_starts;
      reset_a = 1'b0;
      wait_done("p1_done");
      chk("p1_writes_before_done", 32'(n_starts - base), 32'd4);
      chk("p1_err", 32'(err_a), 32'd0);
      wait_ack("p1_ack");
      host_req = 1'b0;
      repeat (40) @(negedge clk);
      chk("p1_acks", 32'(n_acks), 32'd1);
      chk("p1_starts", 32'(n_starts - base), 32'd5);
      chk("p1_queue_empty", 32'(exp_q.size()), 32'd0);

      // host write to camera 1
      push(CAM1, 8'h3A, 8'h04, 1'b1, 1'b0);
      host_req = 1'b1; host_cam = 1'b1; host_sub = 8'h3A; host_wdata = 8'h04;
      wait_ack("p2_ack");
      chk("p2_cam_sel", 32'(cam_a), 32'd1);
      host_req = 1'b0;
      repeat (40) @(negedge clk);
      chk("p2_acks", 32'(n_acks), 32'd2);
      chk("p2_queue_empty", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a busy host write
      push(CAM0, 8'h10, 8'h20, 1'b0, 1'b0);
      host_req = 1'b1; host_cam = 1'b0; host_sub = 8'h10; host_wdata = 8'h20;
      k = 0;
      while (!busy_a && k < 200) begin @(negedge clk); k++; end
      chk("p3_busy_seen", 32'(busy_a), 32'd1);
      host_req = 1'b0;
      reset_a = 1'b1;
      @(negedge clk);
      chk("p3_rst_start", 32'(start_a), 32'd0);
      chk("p3_rst_addr",  32'(addr_a),  32'(CAM0));
      chk("p3_rst_sub",   32'(sub_a),   32'd0);
      chk("p3_rst_wdata", 32'(wdata_a), 32'd0);
      chk("p3_rst_cam",   32'(cam_a),   32'd0);
      chk("p3_rst_ack",   32'(ack_a),   32'd0);
      chk("p3_rst_done",  32'(done_a),  32'd0);
      chk("p3_rst_err",   32'(err_a),   32'd0);
      chk("p3_rst_idx",   32'(idx_a),   32'd0);
      chk("p3_rst_state", 32'(dut_a.state_q), 32'(S_PWRUP));

      // mute SCCB master: every write times out, sequence still completes
      silent_a = 1'b1;
      push_table_a();
      base = n_starts;
      reset_a = 1'b0;
      k = 0;
      while (k < 500) begin
         @(negedge clk); k++;
         if (start_a) break;
      end
      first_cyc = cyc;
      chk_rng("p3_pwrup_quiet", k, int'(PWRUP), 499);
      wait_done("p3_done");
      chk_rng("p3_err_latency", err_cyc - first_cyc, 99, 101);
      chk("p3_err_idx", 32'(err_idx), 32'd1);
      chk("p3_err_sticky", 32'(err_a), 32'd1);
      chk("p3_writes", 32'(n_starts - base), 32'd4);
      chk("p3_queue_empty", 32'(exp_q.size()), 32'd0);

      // table without end marker on dut_b
      sel_b = 1'b1;
      push(CAM0, 8'h12, 8'h80, 1'b0, 1'b0);
      push(CAM0, 8'h13, 8'h01, 1'b0, 1'b0);
      push(CAM0, 8'h14, 8'h02, 1'b0, 1'b0);
      push(CAM0, 8'h15, 8'h03, 1'b0, 1'b0);
      push(CAM1, 8'h12, 8'h80, 1'b1, 1'b0);
      push(CAM1, 8'h13, 8'h01, 1'b1, 1'b0);
      push(CAM1, 8'h14, 8'h02, 1'b1, 1'b0);
      push(CAM1, 8'h15, 8'h03, 1'b1, 1'b0);
      base = n_starts;
      @(negedge clk);
      reset_b = 1'b0;
      wait_done("p4_done");
      chk("p4_writes", 32'(n_starts - base), 32'd8);
      chk("p4_err", 32'(err_b), 32'd0);
      chk("p4_idx", 32'(idx_b), 32'd3);
      chk("p4_cam_sel", 32'(cam_b), 32'd1);
      chk("p4_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
